rr_stream_mux: RTL and testbench
================================

// Module: rr_stream_mux
// PURPOSE
//   Collecting end of the fan-out path: merges IN_INPUTS valid/ready input streams into one output
//   stream. Arbitration is round-robin. Each output beat carries the index of its source on out_sel,
//   so a downstream demultiplexer can route it back by that index.
//   Output is registered: one beat of buffering, 1-cycle latency, full throughput.
// PARAMETERS
//   IN_BITWIDTH  1   width of each data beat
//   IN_INPUTS    16  number of input channels (>=1, any value, not only powers of two)
//   LOG2_OF_IN   max($clog2(IN_INPUTS),1)  width of out_sel (derived; do not override)
// PORTS
//   clk        in   1                     clock, rising edge
//   rst        in   1                     reset, asynchronous, active-high
//   in_data    in   IN_BITWIDTH x [IN_INPUTS]  per-channel data (unpacked array)
//   in_valid   in   IN_INPUTS             per-channel valid
//   in_ready   out  IN_INPUTS             per-channel ready (at most one bit high per cycle)
//   out_data   out  IN_BITWIDTH           merged data
//   out_sel    out  LOG2_OF_IN            source channel index of out_data
//   out_valid  out  1                     output beat valid
//   out_ready  in   1                     downstream ready
// BEHAVIOUR
//   Reset: out_valid=0, out_data='0, out_sel='0, rr pointer=0. in_ready is all zeros
//     while rst is high.
//   Transfer rule: a beat moves on a channel when its valid and ready are both high at a clk edge.
//   load = ~out_valid | out_ready. This lets the output register refill in the same cycle it drains.
//     in_ready = grant & {IN_INPUTS{load}}.
//     out_ready -> in_ready is a combinational path. This is allowed and must be documented for
//     integrators.
//   Arbiter:
//     grant = one-hot. It selects the first index with in_valid high, searching ptr, ptr+1, ...,
//       IN_INPUTS-1, 0, ..., ptr-1.
//     grant is all zeros if no in_valid is high.
//   Pointer update: on any input transfer from channel k, ptr <= (k==IN_INPUTS-1) ? 0 : k+1.
//     Otherwise ptr holds. The explicit compare is required because N may be a non-power-of-two.
//   Output register on load:
//     any grant: out_valid<=1, out_data<=in_data[k], out_sel<=k.
//     no grant: out_valid<=0; out_data and out_sel hold their last values.
//   Stall: while out_valid & ~out_ready, out_data and out_sel stay stable, in_ready stays all 0,
//     and ptr holds.
//   Latency 1 cycle, input handshake to out_valid. Sustained throughput is 1 beat/cycle when
//     out_ready=1.
//   Fairness: with all channels requesting continuously, each channel is served once every
//     IN_INPUTS beats.
//   Input contract: in_valid may drop before it is accepted; the block must not assume inputs hold.
//   IN_INPUTS=1: out_sel is always 0 and ptr stays 0. The block degenerates to a 1-deep pipeline
//     register.
//   Reset mid-operation: a buffered beat is discarded. Outputs return to their reset values
//     immediately (async), without waiting for a clock edge.
//   X-safety: in_data of non-granted channels must never reach out_data.
// STRUCTURE
//   Package mux_pkg holds the function safe_clog2(n) = (n>1) ? $clog2(n) : 1, shared with the
//     demultiplexer width parameter.
//   Sub-module rr_arbiter #(N): inputs req[N], ptr, advance; outputs one-hot grant[N] and
//     grant_idx.
//     The ptr register lives inside rr_arbiter. advance = |in_valid & load.
//   Top level: rr_arbiter instance, in_ready gating, and the output register (always_ff with
//     async reset).
// TESTING
//   1 Reset: assert rst mid-stream with out_valid=1 -> out_valid=0, out_sel=0 and in_ready=0
//     before the next clk edge.
//     After release, the first grant starts the search at channel 0.
//   2 Single source: N=16, W=8, only ch5 valid with data 8'hA5, out_ready=1 -> one cycle later
//     out_valid=1, out_data=A5, out_sel=5. Next grant search starts at ch6.
//   3 Fairness: all 16 channels valid, out_ready=1 -> out_sel sequence is 0,1,...,15,0,1.
//     Each in_ready is high exactly 1 cycle in 16.
//   4 Backpressure: out_ready=0 for 5 cycles with beat {D=3C,sel=2} held -> out_data and out_sel
//     stable, in_ready=0.
//     When out_ready rises, the next beat loads in the same cycle with no bubble.
//   5 Non-power-of-two wrap: N=5, ch4 and ch0 valid, ptr=4 -> grants ch4, then ch0.
//     out_sel never exceeds 4.
//   6 Drain/idle: one beat and then no in_valid -> out_valid falls after the accept, and
//     out_data holds its last value.
//     Also run N=1: out_sel always 0, beats pass with 1-cycle latency.

Source files
------------

// File: rtl/mux_pkg.sv
// Helpers shared by the round-robin stream multiplexer and its matching demultiplexer.
package mux_pkg;

   // Index width for n channels; a single channel still gets a 1-bit index.
   function automatic int safe_clog2(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr, wrapping at N.
// ptr moves to one past the granted index only when advance is high.
module rr_arbiter
   import mux_pkg::*;
#(
   parameter int N     = 16,
   parameter int IDX_W = safe_clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic             advance,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx
);

   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] ptr_d;

   // Circular priority search starting at ptr_q.
   always_comb begin
      int   sum;
      int   cand;
      logic found;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      sum       = 0;
      cand      = 0;
      for (int off = 0; off < N; off++) begin
         sum  = int'(ptr_q) + off;
         cand = (sum >= N) ? (sum - N) : sum;
         if (!found && req[cand]) begin
            grant[cand] = 1'b1;
            grant_idx   = IDX_W'(cand);
            found       = 1'b1;
         end else begin
            found = found;
         end
      end
   end

   // Explicit wrap compare: N need not be a power of two.
   always_comb begin
      if (advance) begin
         ptr_d = (grant_idx == IDX_W'(N - 1)) ? '0 : (grant_idx + IDX_W'(1));
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Pointer register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/rr_stream_mux.sv
// Merges IN_INPUTS valid/ready streams into one registered stream tagged with its source index.
// Integrators: out_ready reaches in_ready through a combinational path (refill while draining).
module rr_stream_mux
   import mux_pkg::*;
#(
   parameter int IN_BITWIDTH = 1,
   parameter int IN_INPUTS   = 16,
   parameter int LOG2_OF_IN  = safe_clog2(IN_INPUTS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [IN_BITWIDTH-1:0] in_data [IN_INPUTS],
   input  logic [IN_INPUTS-1:0]   in_valid,
   output logic [IN_INPUTS-1:0]   in_ready,
   output logic [IN_BITWIDTH-1:0] out_data,
   output logic [LOG2_OF_IN-1:0]  out_sel,
   output logic                   out_valid,
   input  logic                   out_ready
);

   logic                   out_valid_q, out_valid_d;
   logic [IN_BITWIDTH-1:0] out_data_q,  out_data_d;
   logic [LOG2_OF_IN-1:0]  out_sel_q,   out_sel_d;
   logic                   load;
   logic                   advance;
   logic [IN_INPUTS-1:0]   grant;
   logic [LOG2_OF_IN-1:0]  grant_idx;
   logic [IN_BITWIDTH-1:0] picked;

   assign load     = ~out_valid_q | out_ready;
   assign advance  = (|in_valid) & load;
   assign in_ready = rst ? '0 : (grant & {IN_INPUTS{load}});

   rr_arbiter #(
      .N     (IN_INPUTS),
      .IDX_W (LOG2_OF_IN)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (in_valid),
      .advance   (advance),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // AND-OR select keeps non-granted (possibly X) data off the output path.
   always_comb begin
      picked      = '0;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      for (int i = 0; i < IN_INPUTS; i++) begin
         picked = picked | (in_data[i] & {IN_BITWIDTH{grant[i]}});
      end
      if (load) begin
         out_valid_d = |grant;
         if (|grant) begin
            out_data_d = picked;
            out_sel_d  = grant_idx;
         end else begin
            out_data_d = out_data_q;
            out_sel_d  = out_sel_q;
         end
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Output register; reset discards any buffered beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed + random bench for rr_stream_mux at N=16, N=5 and N=1 (W=8), with a reference
// round-robin model feeding per-instance scoreboards.
module tb_rr_stream_mux;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [15:0] v16, ir16;  logic [7:0] d16 [16]; logic [7:0] od16; logic [3:0] os16; logic ov16, or16;
   logic [4:0]  v5,  ir5;   logic [7:0] d5  [5];  logic [7:0] od5;  logic [2:0] os5;  logic ov5,  or5;
   logic [0:0]  v1,  ir1;   logic [7:0] d1  [1];  logic [7:0] od1;  logic [0:0] os1;  logic ov1,  or1;

   rr_stream_mux #(.IN_BITWIDTH(8), .IN_INPUTS(16)) dut16 (
      .clk(clk), .rst(rst), .in_data(d16), .in_valid(v16), .in_ready(ir16),
      .out_data(od16), .out_sel(os16), .out_valid(ov16), .out_ready(or16));
   rr_stream_mux #(.IN_BITWIDTH(8), .IN_INPUTS(5)) dut5 (
      .clk(clk), .rst(rst), .in_data(d5), .in_valid(v5), .in_ready(ir5),
      .out_data(od5), .out_sel(os5), .out_valid(ov5), .out_ready(or5));
   rr_stream_mux #(.IN_BITWIDTH(8), .IN_INPUTS(1)) dut1 (
      .clk(clk), .rst(rst), .in_data(d1), .in_valid(v1), .in_ready(ir1),
      .out_data(od1), .out_sel(os1), .out_valid(ov1), .out_ready(or1));

   int n_assert;
   int n_fail;
   int nch [3] = '{16, 5, 1};

   // Reference model state per instance
   int         ptr_m [3];
   logic       ov_m  [3];
   logic [7:0] od_m  [3];
   int         os_m  [3];
   int         g_s   [3];
   logic       any_s [3];
   logic       load_s[3];
   logic [7:0] gd_s  [3];
   logic [11:0] q0 [$];
   logic [11:0] q1 [$];
   logic [11:0] q2 [$];
   int cnt [16];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] get_v(input int k);
      case (k)
         0:       return v16;
         1:       return {11'd0, v5};
         default: return {15'd0, v1};
      endcase
   endfunction

   function automatic logic [7:0] get_d(input int k, input int i);
      case (k)
         0:       return d16[i];
         1:       return d5[i];
         default: return d1[0];
      endcase
   endfunction

   function automatic logic get_or(input int k);
      case (k)
         0:       return or16;
         1:       return or5;
         default: return or1;
      endcase
   endfunction

   function automatic logic [31:0] get_obs(input int k, input int what);
      case (what)
         0:       return (k == 0) ? 32'(ir16) : (k == 1) ? 32'(ir5) : 32'(ir1);
         1:       return (k == 0) ? 32'(ov16) : (k == 1) ? 32'(ov5) : 32'(ov1);
         2:       return (k == 0) ? 32'(od16) : (k == 1) ? 32'(od5) : 32'(od1);
         default: return (k == 0) ? 32'(os16) : (k == 1) ? 32'(os5) : 32'(os1);
      endcase
   endfunction

   task automatic reset_model(input int k);
      ptr_m[k] = 0; ov_m[k] = 1'b0; od_m[k] = 8'd0; os_m[k] = 0;
      case (k)
         0:       q0.delete();
         1:       q1.delete();
         default: q2.delete();
      endcase
   endtask

   task automatic check_inst(input int k);
      int n, g, c, qs;
      logic any, ld, rdy;
      logic [15:0] vv, one, exp_ir;
      logic [11:0] e;
      n = nch[k]; vv = get_v(k); rdy = get_or(k); one = 16'd1;
      ld = !ov_m[k] || rdy;
      any = 1'b0; g = 0;
      for (int off = 0; off < n; off++) begin
         c = (ptr_m[k] + off) % n;
         if (!any && vv[c]) begin any = 1'b1; g = c; end
      end
      exp_ir = (rst || !ld || !any) ? 16'd0 : (one << g);
      chk($sformatf("in_ready_i%0d", k), get_obs(k, 0), 32'(exp_ir));
      chk($sformatf("out_valid_i%0d", k), get_obs(k, 1), 32'(ov_m[k]));
      chk($sformatf("out_data_i%0d", k), get_obs(k, 2), 32'(od_m[k]));
      chk($sformatf("out_sel_i%0d", k), get_obs(k, 3), 32'(os_m[k]));
      if (ov_m[k] && rdy && !rst) begin
         qs = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
         chk($sformatf("sb_depth_i%0d", k), 32'(qs), 32'd1);
         if (qs > 0) begin
            e = (k == 0) ? q0.pop_front() : (k == 1) ? q1.pop_front() : q2.pop_front();
            chk($sformatf("sb_sel_i%0d", k), get_obs(k, 3), 32'(e[11:8]));
            chk($sformatf("sb_data_i%0d", k), get_obs(k, 2), 32'(e[7:0]));
         end
      end
      g_s[k] = g; any_s[k] = any; load_s[k] = ld; gd_s[k] = any ? get_d(k, g) : 8'd0;
   endtask

   task automatic update(input int k);
      logic [11:0] e;
      if (rst) begin
         reset_model(k);
      end else if (load_s[k]) begin
         if (any_s[k]) begin
            ov_m[k] = 1'b1; od_m[k] = gd_s[k]; os_m[k] = g_s[k];
            ptr_m[k] = (g_s[k] == nch[k] - 1) ? 0 : g_s[k] + 1;
            e = {4'(g_s[k]), gd_s[k]};
            case (k)
               0:       q0.push_back(e);
               1:       q1.push_back(e);
               default: q2.push_back(e);
            endcase
         end else begin
            ov_m[k] = 1'b0;
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      for (int k = 0; k < 3; k++) check_inst(k);
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) update(k);
   endtask

   initial begin
      n_assert = 0; n_fail = 0;
      rst = 1'b1;
      v16 = '0; v5 = '0; v1 = '0; or16 = 1'b1; or5 = 1'b1; or1 = 1'b1;
      for (int i = 0; i < 16; i++) d16[i] = 8'h10 + 8'(i);
      for (int i = 0; i < 5; i++)  d5[i] = 8'h50 + 8'(i);
      d1[0] = 8'h01;
      for (int k = 0; k < 3; k++) reset_model(k);
      @(posedge clk); #1;
      v16 = 16'hFFFF;
      cycle(); cycle();
      rst = 1'b0; v16 = '0;
      cycle();

      // Single source ch5, then search resumes at ch6
      d16[5] = 8'hA5; v16 = 16'h0020;
      cycle();
      v16 = '0;
      chk("single_valid", 32'(ov16), 32'd1);
      chk("single_data", 32'(od16), 32'hA5);
      chk("single_sel", 32'(os16), 32'd5);
      v16 = 16'h0070; #1;
      chk("next_search_ch6", 32'(ir16), 32'h0040);
      cycle();
      v16 = '0; cycle();

      // Reset mid-stream with a beat buffered
      d16[5] = 8'h15; v16 = 16'hFFFF;
      cycle(); cycle();
      rst = 1'b1; #1;
      chk("async_rst_valid", 32'(ov16), 32'd0);
      chk("async_rst_sel", 32'(os16), 32'd0);
      chk("async_rst_ready", 32'(ir16), 32'd0);
      for (int k = 0; k < 3; k++) reset_model(k);
      cycle();
      rst = 1'b0;

      // Fairness with all 16 requesting, starting from ch0 after reset
      for (int i = 0; i < 16; i++) cnt[i] = 0;
      for (int i = 0; i < 18; i++) begin
         #2;
         if (i < 16) for (int j = 0; j < 16; j++) cnt[j] += int'(ir16[j]);
         cycle();
         chk($sformatf("fair_seq_%0d", i), 32'(os16), 32'(i % 16));
      end
      for (int j = 0; j < 16; j++) chk($sformatf("fair_cnt_%0d", j), 32'(cnt[j]), 32'd1);

      // Backpressure on beat {3C, sel 2}
      d16[2] = 8'h3C; d16[3] = 8'hC3; v16 = 16'h0004;
      cycle();
      or16 = 1'b0; v16 = 16'h000C;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("stall_sel", 32'(os16), 32'd2);
         chk("stall_data", 32'(od16), 32'h3C);
         chk("stall_ready", 32'(ir16), 32'd0);
      end
      or16 = 1'b1; #1;
      chk("release_ready", 32'(ir16), 32'h0008);
      cycle();
      chk("no_bubble_valid", 32'(ov16), 32'd1);
      chk("no_bubble_sel", 32'(os16), 32'd3);
      chk("no_bubble_data", 32'(od16), 32'hC3);

      // Drain to idle
      v16 = '0;
      cycle();
      chk("drain_valid", 32'(ov16), 32'd0);
      chk("drain_data_hold", 32'(od16), 32'hC3);
      chk("drain_sel_hold", 32'(os16), 32'd3);
      cycle();

      // N=5 wrap: ptr moved to 4 by a ch3 beat, then ch4 and ch0 compete
      d5[3] = 8'h33; v5 = 5'b01000;
      cycle();
      d5[4] = 8'h44; d5[0] = 8'h0A; v5 = 5'b10001;
      cycle();
      chk("n5_wrap_first", 32'(os5), 32'd4);
      cycle();
      chk("n5_wrap_second", 32'(os5), 32'd0);
      chk("n5_wrap_data", 32'(od5), 32'h0A);
      v5 = '0; cycle();

      // N=1 pipeline
      d1[0] = 8'h77; v1 = 1'b1;
      cycle();
      v1 = 1'b0;
      chk("n1_valid", 32'(ov1), 32'd1);
      chk("n1_sel", 32'(os1), 32'd0);
      chk("n1_data", 32'(od1), 32'h77);
      cycle();
      chk("n1_idle", 32'(ov1), 32'd0);

      // Random traffic with dropping valids and random backpressure
      for (int t = 0; t < 120; t++) begin
         v16 = 16'($urandom); v5 = 5'($urandom); v1 = 1'($urandom);
         for (int i = 0; i < 16; i++) d16[i] = 8'($urandom);
         for (int i = 0; i < 5; i++)  d5[i] = 8'($urandom);
         d1[0] = 8'($urandom);
         or16 = ($urandom_range(3, 0) != 0); or5 = ($urandom_range(3, 0) != 0); or1 = ($urandom_range(1, 0) != 0);
         cycle();
         chk("n5_sel_range", 32'(os5 <= 3'd4), 32'd1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
